// File: rtl/sig_deglitch_pulse.sv
// Deglitch filter + edge pulse: synchronizes i_sig, accepts a level change after FILT_CYC_NUM stable samples.
// Latency: commit SYNC_STG+FILT_CYC_NUM-1 edges after the first edge sampling the new level; outputs registered.
// Backpressure: none; o_vld/o_glitch are single-cycle strobes that downstream must take when issued.
module sig_deglitch_pulse #(
    parameter int   FILT_CYC_NUM = 8,
    parameter int   SYNC_STG     = 2,
    parameter logic INIT_LVL     = 1'b0,
    parameter int   EDGE_MODE    = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    input  logic i_en,
    output logic o_vld,
    output logic o_vld_data,
    output logic o_lvl,
    output logic o_glitch
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_CHK    = 1'b1;
    localparam logic [7:0] FILT_LAST = 8'(FILT_CYC_NUM - 1);

    logic [SYNC_STG-1:0] sync_q;
    logic                s;
    logic [0:0]          state;
    logic [0:0]          state_nxt;
    logic [7:0]          cnt;
    logic [7:0]          cnt_nxt;
    logic                commit;
    logic                abandon;
    logic                lvl_nxt;
    logic                edge_ok;

    assign s       = sync_q[SYNC_STG-1];
    assign lvl_nxt = ~o_lvl;
    assign edge_ok = (EDGE_MODE == 0) ||
                     ((EDGE_MODE == 1) &&  lvl_nxt) ||
                     ((EDGE_MODE == 2) && !lvl_nxt);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        abandon   = 1'b0;
        if (!i_en) begin
            // Disabling silently drops any candidate; no glitch is reported.
            state_nxt = ST_IDLE;
            cnt_nxt   = 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_nxt = 8'd0;
                    if (s != o_lvl) begin
                        if (FILT_CYC_NUM == 1) begin
                            commit = 1'b1;
                        end else begin
                            state_nxt = ST_CHK;
                            cnt_nxt   = 8'd1;
                        end
                    end
                end
                ST_CHK: begin
                    if (s != o_lvl) begin
                        if (cnt == FILT_LAST) begin
                            commit    = 1'b1;
                            state_nxt = ST_IDLE;
                            cnt_nxt   = 8'd0;
                        end else if (cnt != 8'hFF) begin
                            cnt_nxt = cnt + 8'd1;
                        end
                    end else begin
                        abandon   = 1'b1;
                        state_nxt = ST_IDLE;
                        cnt_nxt   = 8'd0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q     <= {SYNC_STG{INIT_LVL}};
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            o_lvl      <= INIT_LVL;
            o_vld      <= 1'b0;
            o_vld_data <= 1'b0;
            o_glitch   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STG-2:0], i_sig};
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            o_vld      <= commit && edge_ok;
            o_vld_data <= commit && edge_ok && lvl_nxt;
            o_glitch   <= abandon;
            if (commit) begin
                o_lvl <= lvl_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sig_deglitch_pulse.sv
// Directed bench for sig_deglitch_pulse: default, rising-only and single-sample instances share stimulus.
module tb_sig_deglitch_pulse;

    logic clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_sig = 1'b0;
    logic i_en  = 1'b1;

    logic d_vld, d_dat, d_lvl, d_gl;
    logic e_vld, e_dat, e_lvl, e_gl;
    logic f_vld, f_dat, f_lvl, f_gl;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sig_deglitch_pulse u_def (
        .i_clk(clk), .i_rst(i_rst), .i_sig(i_sig), .i_en(i_en),
        .o_vld(d_vld), .o_vld_data(d_dat), .o_lvl(d_lvl), .o_glitch(d_gl)
    );

    sig_deglitch_pulse #(.EDGE_MODE(1)) u_rise (
        .i_clk(clk), .i_rst(i_rst), .i_sig(i_sig), .i_en(i_en),
        .o_vld(e_vld), .o_vld_data(e_dat), .o_lvl(e_lvl), .o_glitch(e_gl)
    );

    sig_deglitch_pulse #(.FILT_CYC_NUM(1)) u_f1 (
        .i_clk(clk), .i_rst(i_rst), .i_sig(i_sig), .i_en(i_en),
        .o_vld(f_vld), .o_vld_data(f_dat), .o_lvl(f_lvl), .o_glitch(f_gl)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves reset released with i_sig at v; the next edge is the first sampling edge.
    task automatic do_reset(input logic v);
        i_rst = 1'b1;
        i_en  = 1'b1;
        i_sig = v;
        repeat (3) tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        i_en  = 1'b1;
        i_sig = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({d_lvl, d_vld, d_dat, d_gl} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold: lvl/vld/dat/gl=%b expected 0000", {d_lvl, d_vld, d_dat, d_gl});
            end
        end
        i_rst = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            checks++;
            if (d_vld !== (k == 10)) begin
                errors++;
                $display("FAIL reset_release_vld tick %0d: vld=%b expected %b", k, d_vld, (k == 10));
            end
            if (k == 10) begin
                checks++;
                if (d_dat !== 1'b1 || d_lvl !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_release_data: dat=%b lvl=%b expected 1 1", d_dat, d_lvl);
                end
            end
        end
    endtask

    task automatic test_rise;
        int nv;
        int ng;
        nv = 0;
        ng = 0;
        do_reset(1'b0);
        i_sig = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (d_vld) nv++;
            if (d_gl) ng++;
            if (k == 9) begin
                checks++;
                if (d_lvl !== 1'b0) begin
                    errors++;
                    $display("FAIL rise_early_lvl: lvl=%b expected 0", d_lvl);
                end
            end
            if (k == 10) begin
                checks++;
                if (d_vld !== 1'b1 || d_dat !== 1'b1 || d_lvl !== 1'b1) begin
                    errors++;
                    $display("FAIL rise_pulse: vld=%b dat=%b lvl=%b expected 1 1 1", d_vld, d_dat, d_lvl);
                end
            end
        end
        checks++;
        if (nv !== 1 || ng !== 0 || d_lvl !== 1'b1) begin
            errors++;
            $display("FAIL rise_counts: vld_cnt=%0d glitch_cnt=%0d lvl=%b expected 1 0 1", nv, ng, d_lvl);
        end
    endtask

    task automatic test_glitch;
        int nv;
        int ng;
        // Seven sampled high cycles: one short of acceptance.
        nv = 0;
        ng = 0;
        do_reset(1'b0);
        for (int k = 1; k <= 20; k++) begin
            i_sig = (k <= 7);
            tick();
            if (d_vld) nv++;
            if (d_gl) ng++;
            checks++;
            if (d_vld && d_gl) begin
                errors++;
                $display("FAIL glitch7_overlap tick %0d: vld=1 glitch=1 expected not both", k);
            end
            if (k == 10) begin
                checks++;
                if (d_gl !== 1'b1) begin
                    errors++;
                    $display("FAIL glitch7_pulse: glitch=%b expected 1", d_gl);
                end
            end
        end
        checks++;
        if (nv !== 0 || ng !== 1 || d_lvl !== 1'b0) begin
            errors++;
            $display("FAIL glitch7_counts: vld_cnt=%0d glitch_cnt=%0d lvl=%b expected 0 1 0", nv, ng, d_lvl);
        end

        // Eight high cycles: accepted, then the return low is accepted as a falling edge.
        nv = 0;
        ng = 0;
        do_reset(1'b0);
        for (int k = 1; k <= 22; k++) begin
            i_sig = (k <= 8);
            tick();
            if (d_vld) nv++;
            if (d_gl) ng++;
            if (k == 15) begin
                checks++;
                if (nv !== 1 || d_lvl !== 1'b1) begin
                    errors++;
                    $display("FAIL glitch8_accept: vld_cnt=%0d lvl=%b expected 1 1", nv, d_lvl);
                end
            end
            if (k == 18) begin
                checks++;
                if (d_vld !== 1'b1 || d_dat !== 1'b0 || d_lvl !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch8_fall: vld=%b dat=%b lvl=%b expected 1 0 0", d_vld, d_dat, d_lvl);
                end
            end
        end
        checks++;
        if (nv !== 2 || ng !== 0) begin
            errors++;
            $display("FAIL glitch8_counts: vld_cnt=%0d glitch_cnt=%0d expected 2 0", nv, ng);
        end
    endtask

    task automatic test_edge_mode;
        int nv;
        nv = 0;
        do_reset(1'b0);
        i_sig = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (e_vld) nv++;
            if (k == 10) begin
                checks++;
                if (e_vld !== 1'b1 || e_dat !== 1'b1) begin
                    errors++;
                    $display("FAIL edge_rise: vld=%b dat=%b expected 1 1", e_vld, e_dat);
                end
            end
        end
        i_sig = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (e_vld) nv++;
            if (k == 9 || k == 10) begin
                checks++;
                if (e_lvl !== (k == 9)) begin
                    errors++;
                    $display("FAIL edge_fall_lvl tick %0d: lvl=%b expected %b", k, e_lvl, (k == 9));
                end
            end
        end
        checks++;
        if (nv !== 1 || e_gl !== 1'b0) begin
            errors++;
            $display("FAIL edge_counts: vld_cnt=%0d glitch=%b expected 1 0", nv, e_gl);
        end
    endtask

    task automatic test_filt1;
        logic drv [1:12];
        logic cur;
        do_reset(1'b0);
        i_sig = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (f_vld !== (k == 3)) begin
                errors++;
                $display("FAIL filt1_latency tick %0d: vld=%b expected %b", k, f_vld, (k == 3));
            end
        end
        cur = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            cur    = ~cur;
            drv[j] = cur;
            i_sig  = cur;
            tick();
            checks++;
            if (j >= 3) begin
                if (f_vld !== 1'b1 || f_dat !== drv[j-2] || f_gl !== 1'b0) begin
                    errors++;
                    $display("FAIL filt1_alt %0d: vld=%b dat=%b gl=%b expected 1 %b 0", j, f_vld, f_dat, f_gl, drv[j-2]);
                end
            end else if (f_vld !== 1'b0) begin
                errors++;
                $display("FAIL filt1_alt_start %0d: vld=%b expected 0", j, f_vld);
            end
        end
    endtask

    task automatic test_enable;
        do_reset(1'b0);
        i_sig = 1'b1;
        // Tick 6 leaves cnt at 4 in the default instance.
        repeat (6) tick();
        i_en = 1'b0;
        for (int k = 7; k <= 9; k++) begin
            tick();
            checks++;
            if (d_vld !== 1'b0 || d_gl !== 1'b0 || d_lvl !== 1'b0) begin
                errors++;
                $display("FAIL en_off tick %0d: vld=%b gl=%b lvl=%b expected 0 0 0", k, d_vld, d_gl, d_lvl);
            end
        end
        i_en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (d_vld !== (k == 8) || d_gl !== 1'b0) begin
                errors++;
                $display("FAIL en_restart tick %0d: vld=%b gl=%b expected %b 0", k, d_vld, d_gl, (k == 8));
            end
        end
        checks++;
        if (d_lvl !== 1'b1) begin
            errors++;
            $display("FAIL en_restart_lvl: lvl=%b expected 1", d_lvl);
        end
    endtask

    task automatic test_reset_mid_chk;
        do_reset(1'b0);
        i_sig = 1'b1;
        repeat (7) tick();
        i_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({d_lvl, d_vld, d_dat, d_gl} !== 4'b0000) begin
                errors++;
                $display("FAIL rst_mid_hold: lvl/vld/dat/gl=%b expected 0000", {d_lvl, d_vld, d_dat, d_gl});
            end
        end
        i_sig = 1'b0;
        i_rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if ({d_lvl, d_vld, d_gl} !== 3'b000) begin
                errors++;
                $display("FAIL rst_mid_after tick %0d: lvl/vld/gl=%b expected 000", k, {d_lvl, d_vld, d_gl});
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_edge_mode();
        test_filt1();
        test_enable();
        test_reset_mid_chk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
